fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction presented when the fetch slot is empty.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port stall_i, input, 1, hold the fetch slot; OR of all RAW/load-to-branch hazard checks.
REQ-006 SHALL have port redirect_valid_i, input, 1, taken branch/jump resolved downstream.
REQ-007 SHALL have port redirect_pc_i, input, 32, redirect target.
REQ-008 SHALL have port imem_req_o, output, 1, instruction memory request.
REQ-009 SHALL have port imem_addr_o, output, 32, request address, word aligned.
REQ-010 SHALL have port imem_ready_i, input, 1, memory accepts the request and returns data this cycle.
REQ-011 SHALL have port imem_rdata_i, input, 32, instruction data, valid when imem_req_o && imem_ready_i.
REQ-012 SHALL have port instr_f_o, output, 32, instruction in the fetch slot.
REQ-013 SHALL have port pc_f_o, output, 32, PC of instr_f_o.
REQ-014 SHALL have port valid_f_o, output, 1, fetch slot holds a real instruction.
REQ-015 SHALL have port rs1_f_o, output, 5, instr_f_o[19:15].
REQ-016 SHALL have port rs2_f_o, output, 5, instr_f_o[24:20].

Function
REQ-017 SHALL implement a two-state FSM: BOOT (entered on reset, imem_req_o=0) -> RUN unconditionally on the next edge; RUN is held until reset.
REQ-018 SHALL hold a fetch PC register, a one-entry output slot (instr, pc, valid) and a one-entry skid buffer (instr, pc, valid).
REQ-019 SHALL drive imem_req_o = (state==RUN) && !skid_valid && !redirect_valid_i, and imem_addr_o = fetch PC.
REQ-020 SHALL treat imem_req_o && imem_ready_i as a transfer; fetch PC advances by 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) on each transfer.
REQ-021 SHALL consider the slot consumed in a cycle when valid_f_o && !stall_i.
REQ-022 SHALL load transfer data into the slot when the slot is empty or consumed that cycle; otherwise it SHALL load the data into the skid buffer.
REQ-023 SHALL move skid contents into the slot when the slot is consumed and no transfer occurs that cycle; the skid then becomes empty.
REQ-024 SHALL keep imem_addr_o stable while imem_req_o is high and no transfer or redirect occurs.
REQ-025 SHALL, on redirect_valid_i, clear slot and skid valid, load fetch PC with {redirect_pc_i[31:2],2'b00}, and issue no transfer that cycle; redirect SHALL take priority over stall_i.
REQ-026 SHALL present instr_f_o = NOP_INSTR (and rs1/rs2 from it) whenever valid_f_o=0; pc_f_o SHALL hold its last value.
REQ-027 SHALL never lose or duplicate an instruction: slot-consumption order equals transfer order between redirects.
REQ-028 SHALL tolerate any number of imem_ready_i=0 cycles; imem_ready_i while imem_req_o=0 SHALL be ignored.
REQ-029 SHALL produce rs1_f_o/rs2_f_o combinationally from instr_f_o.

Reset
REQ-030 SHALL, while rst_n=0, set state=BOOT, fetch PC=RESET_PC, slot and skid valid=0, pc_f_o=RESET_PC, instr_f_o=NOP_INSTR, imem_req_o=0.
REQ-031 SHALL, on rst_n assertion mid-transfer or mid-stall, discard all buffered instructions immediately; first request after release is to RESET_PC, one cycle after BOOT.

Verification
REQ-032 Reset release, imem_ready_i=1 always, stall_i=0 -> requests at 0x0,0x4,0x8 on consecutive cycles; slot shows them one cycle later, valid_f_o=1 continuously.
REQ-033 Memory with 3-cycle ready latency -> imem_addr_o held 3 cycles; valid_f_o pulses once per instruction with NOP between.
REQ-034 stall_i held 4 cycles with ready=1 -> slot frozen at 0x8, skid takes 0xC, imem_req_o drops; on release 0xC then 0x10 appear in order.
REQ-035 redirect_valid_i with redirect_pc_i=0x103 while skid full -> both flushed, valid_f_o=0 next cycle, next request to 0x100.
REQ-036 redirect_valid_i and stall_i asserted together -> redirect wins; no instruction from before redirect ever reaches the slot.
REQ-037 Redirect to 0xFFFF_FFFC -> subsequent requests 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, buffers returned
// words in a one-entry output slot backed by a one-entry skid buffer.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic        valid_f_o,
  output logic [4:0]  rs1_f_o,
  output logic [4:0]  rs2_f_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [31:0] r_fetchPc;
  logic [31:0] r_slotInstr;
  logic [31:0] r_slotPc;
  logic        r_slotValid;
  logic [31:0] r_skidInstr;
  logic [31:0] r_skidPc;
  logic        r_skidValid;

  logic        w_req;
  logic        w_xfer;
  logic        w_consume;
  logic        w_slotFree;
  logic [31:0] w_redirectPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Requests are withheld while the skid is occupied so at most two words are ever in flight.
  always_comb begin
    w_nextState = r_state;
    w_req       = 1'b0;
    case (r_state)
      BOOT: begin
        w_nextState = RUN;
      end
      RUN: begin
        w_req = !r_skidValid && !redirect_valid_i;
      end
      default: begin
        w_nextState = BOOT;
      end
    endcase
  end

  assign w_xfer       = w_req && imem_ready_i;
  assign w_consume    = r_slotValid && !stall_i;
  assign w_slotFree   = !r_slotValid || w_consume;
  assign w_redirectPc = redirect_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc <= RESET_PC;
    end else if (redirect_valid_i) begin
      r_fetchPc <= w_redirectPc;
    end else if (w_xfer) begin
      r_fetchPc <= r_fetchPc + 32'd4;
    end
  end

  // A transfer can only target the skid when it is empty, because w_req excludes a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotInstr <= NOP_INSTR;
      r_slotPc    <= RESET_PC;
      r_slotValid <= 1'b0;
      r_skidInstr <= NOP_INSTR;
      r_skidPc    <= RESET_PC;
      r_skidValid <= 1'b0;
    end else if (redirect_valid_i) begin
      r_slotValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_xfer) begin
      if (w_slotFree) begin
        r_slotInstr <= imem_rdata_i;
        r_slotPc    <= r_fetchPc;
        r_slotValid <= 1'b1;
      end else begin
        r_skidInstr <= imem_rdata_i;
        r_skidPc    <= r_fetchPc;
        r_skidValid <= 1'b1;
      end
    end else if (w_consume) begin
      if (r_skidValid) begin
        r_slotInstr <= r_skidInstr;
        r_slotPc    <= r_skidPc;
        r_slotValid <= 1'b1;
        r_skidValid <= 1'b0;
      end else begin
        r_slotValid <= 1'b0;
      end
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetchPc;
  assign valid_f_o   = r_slotValid;
  assign pc_f_o      = r_slotPc;
  assign instr_f_o   = r_slotValid ? r_slotInstr : NOP_INSTR;
  assign rs1_f_o     = instr_f_o[19:15];
  assign rs2_f_o     = instr_f_o[24:20];

endmodule
